// File: rtl/rf_pkg.sv
// Shared constants and writeback payload for the register-file access path.
package rf_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot register mask for scoreboard set/clear.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    return NREGS'(1) << a;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous writeback FIFO of wb_entry_t; DEPTH must be a power of two, >= 2.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  wb_entry_t              i_wdata,
  input  logic                   i_pop,
  output wb_entry_t              o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A full FIFO refuses a push even when the head pops in the same cycle.
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file requester: operand capture, busy scoreboard, hazard stall, writeback commit.
// Define RF_BYPASS_EN to forward the committing writeback into decode instead of stalling.
module rf_access_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [ADDR_W-1:0]         dec_src1,
  input  logic [ADDR_W-1:0]         dec_src2,
  input  logic [ADDR_W-1:0]         dec_dst,
  input  logic                      dec_wen,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [DATA_W-1:0]         op_a,
  output logic [DATA_W-1:0]         op_b,
  output logic [ADDR_W-1:0]         op_dst,
  output logic                      op_wen,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [ADDR_W-1:0]         rf_r_addr1,
  output logic [ADDR_W-1:0]         rf_r_addr2,
  input  logic [DATA_W-1:0]         rf_r_data1,
  input  logic [DATA_W-1:0]         rf_r_data2,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_w_addr,
  output logic [DATA_W-1:0]         rf_w_data,
  output logic [$clog2(WB_DEPTH):0] wb_count
);

  localparam int unsigned CNT_W = $clog2(WB_DEPTH) + 1;

  logic [NREGS-1:0]  r_busy;
  logic              r_op_valid;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [ADDR_W-1:0] r_op_dst;
  logic              r_op_wen;

  wb_entry_t         w_wb_in;
  wb_entry_t         w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_fwd1;
  logic              w_fwd2;
  logic              w_fwdd;
  logic              w_hazard;
  logic              w_slot_free;
  logic              w_accept;
  logic [DATA_W-1:0] w_opa_next;
  logic [DATA_W-1:0] w_opb_next;
  logic [NREGS-1:0]  w_set_mask;
  logic [NREGS-1:0]  w_clr_mask;

  assign w_wb_in.addr = wb_addr;
  assign w_wb_in.data = wb_data;

  rf_wb_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (wb_valid),
    .i_wdata (w_wb_in),
    .i_pop   (~w_empty),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The FIFO head retires into the register file every cycle it is occupied.
  assign rf_we     = ~w_empty;
  assign rf_w_addr = w_head.addr;
  assign rf_w_data = w_head.data;
  assign wb_ready  = ~w_full;
  assign wb_count  = w_count;

  assign rf_r_addr1 = dec_src1;
  assign rf_r_addr2 = dec_src2;

`ifdef RF_BYPASS_EN
  assign w_fwd1 = rf_we & (rf_w_addr == dec_src1);
  assign w_fwd2 = rf_we & (rf_w_addr == dec_src2);
  assign w_fwdd = rf_we & (rf_w_addr == dec_dst);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
  assign w_fwdd = 1'b0;
`endif

  // A busy register being committed this cycle is resolved by the forward path.
  assign w_hazard = (r_busy[dec_src1] & ~w_fwd1)
                  | (r_busy[dec_src2] & ~w_fwd2)
                  | (dec_wen & r_busy[dec_dst] & ~w_fwdd);

  assign w_slot_free = ~r_op_valid | op_ready;
  assign dec_ready   = w_slot_free & ~w_hazard;
  assign w_accept    = dec_valid & dec_ready;

  assign w_opa_next = w_fwd1 ? rf_w_data : rf_r_data1;
  assign w_opb_next = w_fwd2 ? rf_w_data : rf_r_data2;

  assign w_set_mask = (w_accept & dec_wen) ? reg_onehot(dec_dst) : '0;
  assign w_clr_mask = rf_we ? reg_onehot(rf_w_addr) : '0;

  // Set is applied after clear so a same-cycle re-issue keeps the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_dst   <= '0;
      r_op_wen   <= 1'b0;
    end else if (w_accept) begin
      r_op_valid <= 1'b1;
      r_op_a     <= w_opa_next;
      r_op_b     <= w_opb_next;
      r_op_dst   <= dec_dst;
      r_op_wen   <= dec_wen;
    end else if (op_ready) begin
      r_op_valid <= 1'b0;
    end
  end

  assign op_valid = r_op_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_dst   = r_op_dst;
  assign op_wen   = r_op_wen;

  // Committing to a register with no outstanding writer is an execute-side protocol error.
  a_wb_to_busy: assert property (@(posedge clk) disable iff (!rst_n) rf_we |-> r_busy[rf_w_addr]);

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 16x16 register file on the rf_* ports.
module tb_rf_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_src1;
  logic [3:0]  dec_src2;
  logic [3:0]  dec_dst;
  logic        dec_wen;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_dst;
  logic        op_wen;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  rf_r_addr1;
  logic [3:0]  rf_r_addr2;
  logic [15:0] rf_r_data1;
  logic [15:0] rf_r_data2;
  logic        rf_we;
  logic [3:0]  rf_w_addr;
  logic [15:0] rf_w_data;
  logic [2:0]  wb_count;

  logic [15:0] rf_mem [16];
  logic        rf_init;

  int total;
  int bad;

  rf_access_ctrl #(.WB_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_src1   (dec_src1),
    .dec_src2   (dec_src2),
    .dec_dst    (dec_dst),
    .dec_wen    (dec_wen),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_dst     (op_dst),
    .op_wen     (op_wen),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rf_r_addr1 (rf_r_addr1),
    .rf_r_addr2 (rf_r_addr2),
    .rf_r_data1 (rf_r_data1),
    .rf_r_data2 (rf_r_data2),
    .rf_we      (rf_we),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: register i starts at 0x1000+i, written on commit.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 16'h1000 + 16'(i);
    end else if (rf_we) begin
      rf_mem[rf_w_addr] <= rf_w_data;
    end
  end
  assign rf_r_data1 = rf_mem[rf_r_addr1];
  assign rf_r_data2 = rf_mem[rf_r_addr2];

  task automatic test_reset();
    rst_n = 1'b0; rf_init = 1'b1;
    dec_valid = 1'b0; dec_src1 = 4'd0; dec_src2 = 4'd0; dec_dst = 4'd0; dec_wen = 1'b0;
    op_ready = 1'b1; wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 16'h0;
    repeat (3) @(negedge clk);
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%0h exp=0", op_valid); end
    total++; if (op_a !== 16'h0) begin bad++; $display("FAIL reset_op_a got=%0h exp=0", op_a); end
    total++; if (op_b !== 16'h0) begin bad++; $display("FAIL reset_op_b got=%0h exp=0", op_b); end
    total++; if (op_dst !== 4'h0) begin bad++; $display("FAIL reset_op_dst got=%0h exp=0", op_dst); end
    total++; if (op_wen !== 1'b0) begin bad++; $display("FAIL reset_op_wen got=%0h exp=0", op_wen); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
    total++; if (rf_w_addr !== 4'h0) begin bad++; $display("FAIL reset_rf_w_addr got=%0h exp=0", rf_w_addr); end
    total++; if (rf_w_data !== 16'h0) begin bad++; $display("FAIL reset_rf_w_data got=%0h exp=0", rf_w_data); end
    total++; if (wb_count !== 3'd0) begin bad++; $display("FAIL reset_wb_count got=%0d exp=0", wb_count); end
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL reset_wb_ready got=%0h exp=1", wb_ready); end
    rst_n = 1'b1; rf_init = 1'b0;
    @(negedge clk);
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL reset_dec_ready got=%0h exp=1", dec_ready); end
  endtask

  task automatic test_raw();
    dec_valid = 1'b1; dec_src1 = 4'd1; dec_src2 = 4'd2; dec_dst = 4'd3; dec_wen = 1'b1; op_ready = 1'b1;
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL raw_first_ready got=%0h exp=1", dec_ready); end
    @(negedge clk);
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL raw_op_valid got=%0h exp=1", op_valid); end
    total++; if (op_a !== 16'h1001) begin bad++; $display("FAIL raw_op_a got=%0h exp=1001", op_a); end
    total++; if (op_b !== 16'h1002) begin bad++; $display("FAIL raw_op_b got=%0h exp=1002", op_b); end
    total++; if (op_dst !== 4'd3) begin bad++; $display("FAIL raw_op_dst got=%0h exp=3", op_dst); end
    total++; if (op_wen !== 1'b1) begin bad++; $display("FAIL raw_op_wen got=%0h exp=1", op_wen); end
    dec_src1 = 4'd3; dec_src2 = 4'd0; dec_dst = 4'd10; dec_wen = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'h00AB;
    #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%0h exp=0", dec_ready); end
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL raw_commit_we got=%0h exp=1", rf_we); end
    total++; if (rf_w_addr !== 4'd3) begin bad++; $display("FAIL raw_commit_addr got=%0h exp=3", rf_w_addr); end
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL raw_bundle_drained got=%0h exp=0", op_valid); end
`ifdef RF_BYPASS_EN
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL raw_bypass_ready got=%0h exp=1", dec_ready); end
    @(negedge clk);
`else
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL raw_commit_stall got=%0h exp=0", dec_ready); end
    @(negedge clk);
    #1;
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL raw_still_empty got=%0h exp=0", op_valid); end
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL raw_late_ready got=%0h exp=1", dec_ready); end
    @(negedge clk);
`endif
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL raw_second_valid got=%0h exp=1", op_valid); end
    total++; if (op_a !== 16'h00AB) begin bad++; $display("FAIL raw_second_op_a got=%0h exp=00ab", op_a); end
    total++; if (op_b !== 16'h1000) begin bad++; $display("FAIL raw_second_op_b got=%0h exp=1000", op_b); end
    dec_valid = 1'b0;
    @(negedge clk);
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL raw_consumed got=%0h exp=0", op_valid); end
  endtask

  task automatic test_drain_order();
    logic [3:0] got [$];
    logic [3:0] act;
    dec_valid = 1'b1; dec_src1 = 4'd0; dec_src2 = 4'd0; dec_wen = 1'b1; op_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dec_dst = 4'(5 + k);
      #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL drain_issue%0d got=%0h exp=1", k, dec_ready); end
      @(negedge clk);
    end
    dec_valid = 1'b0; dec_wen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        wb_valid = 1'b1; wb_addr = 4'(5 + c); wb_data = 16'h0050 + 16'(c);
      end else begin
        wb_valid = 1'b0;
      end
      #1;
      total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL drain_wb_ready c%0d got=%0h exp=1", c, wb_ready); end
      total++; if (wb_count !== ((c >= 1 && c <= 4) ? 3'd1 : 3'd0)) begin bad++; $display("FAIL drain_count c%0d got=%0d", c, wb_count); end
      if (rf_we === 1'b1) got.push_back(rf_w_addr);
      @(negedge clk);
    end
    total++; if (got.size() != 4) begin bad++; $display("FAIL drain_commits got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      act = (k < got.size()) ? got[k] : 4'hx;
      total++; if (act !== 4'(5 + k)) begin bad++; $display("FAIL drain_order%0d got=%0h exp=%0h", k, act, 5 + k); end
    end
    total++; if (rf_mem[8] !== 16'h0053) begin bad++; $display("FAIL drain_r8 got=%0h exp=0053", rf_mem[8]); end
  endtask

  task automatic test_hold();
    dec_valid = 1'b1; dec_src1 = 4'd1; dec_src2 = 4'd2; dec_dst = 4'd11; dec_wen = 1'b1; op_ready = 1'b0;
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL hold_first_ready got=%0h exp=1", dec_ready); end
    @(negedge clk);
    dec_src1 = 4'd4; dec_src2 = 4'd5; dec_dst = 4'd12; dec_wen = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d got=%0h exp=0", k, dec_ready); end
      @(negedge clk);
      total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL hold_valid%0d got=%0h exp=1", k, op_valid); end
      total++; if (op_a !== 16'h1001) begin bad++; $display("FAIL hold_op_a%0d got=%0h exp=1001", k, op_a); end
      total++; if (op_b !== 16'h1002) begin bad++; $display("FAIL hold_op_b%0d got=%0h exp=1002", k, op_b); end
      total++; if (op_dst !== 4'd11) begin bad++; $display("FAIL hold_op_dst%0d got=%0h exp=b", k, op_dst); end
    end
    op_ready = 1'b1; dec_src1 = 4'd12; dec_src2 = 4'd12; dec_dst = 4'd13; dec_wen = 1'b0;
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL hold_no_busy12 got=%0h exp=1", dec_ready); end
    @(negedge clk);
    total++; if (op_a !== 16'h100C) begin bad++; $display("FAIL hold_next_op_a got=%0h exp=100c", op_a); end
    total++; if (op_dst !== 4'd13) begin bad++; $display("FAIL hold_next_dst got=%0h exp=d", op_dst); end
    total++; if (op_wen !== 1'b0) begin bad++; $display("FAIL hold_next_wen got=%0h exp=0", op_wen); end
    dec_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd11; wb_data = 16'h0BBB;
    @(negedge clk);
    wb_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_waw();
    int n;
    int exp_n;
`ifdef RF_BYPASS_EN
    exp_n = 0;
`else
    exp_n = 1;
`endif
    dec_valid = 1'b1; dec_src1 = 4'd0; dec_src2 = 4'd0; dec_dst = 4'd4; dec_wen = 1'b1; op_ready = 1'b1;
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL waw_first_ready got=%0h exp=1", dec_ready); end
    @(negedge clk);
    #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL waw_stall got=%0h exp=0", dec_ready); end
    wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 16'h0044;
    @(negedge clk);
    wb_valid = 1'b0;
    n = 0;
    #1;
    while (dec_ready !== 1'b1 && n < 6) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++; if (n != exp_n) begin bad++; $display("FAIL waw_wait_cycles got=%0d exp=%0d", n, exp_n); end
    @(negedge clk);
    total++; if (op_dst !== 4'd4 || op_wen !== 1'b1) begin bad++; $display("FAIL waw_reissue got=%0h/%0h exp=4/1", op_dst, op_wen); end
    dec_wen = 1'b0; dec_src1 = 4'd4; dec_dst = 4'd0;
    #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL waw_busy_kept got=%0h exp=0", dec_ready); end
    dec_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 16'h0444;
    @(negedge clk);
    wb_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rf_mem[4] !== 16'h0444) begin bad++; $display("FAIL waw_final_r4 got=%0h exp=0444", rf_mem[4]); end
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b0; dec_valid = 1'b1; dec_src1 = 4'd0; dec_src2 = 4'd0; dec_dst = 4'd14; dec_wen = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd14; wb_data = 16'h0EEE;
    @(negedge clk);
    wb_valid = 1'b0;
    #2;
    total++; if (rf_we !== 1'b1 || op_valid !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%0h/%0h exp=1/1", rf_we, op_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL rmid_op_valid got=%0h exp=0", op_valid); end
    total++; if (op_a !== 16'h0 || op_b !== 16'h0) begin bad++; $display("FAIL rmid_ops got=%0h/%0h exp=0/0", op_a, op_b); end
    total++; if (op_dst !== 4'h0 || op_wen !== 1'b0) begin bad++; $display("FAIL rmid_dst got=%0h/%0h exp=0/0", op_dst, op_wen); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rmid_rf_we got=%0h exp=0", rf_we); end
    total++; if (wb_count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", wb_count); end
    total++; if (rf_w_addr !== 4'h0 || rf_w_data !== 16'h0) begin bad++; $display("FAIL rmid_head got=%0h/%0h exp=0/0", rf_w_addr, rf_w_data); end
    @(negedge clk);
    rst_n = 1'b1; op_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rmid_no_commit_we got=%0h exp=0", rf_we); end
    total++; if (rf_mem[14] !== 16'h100E) begin bad++; $display("FAIL rmid_r14 got=%0h exp=100e", rf_mem[14]); end
    dec_valid = 1'b1; dec_src1 = 4'd14; dec_dst = 4'd14; dec_wen = 1'b1;
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL rmid_busy_cleared got=%0h exp=1", dec_ready); end
    dec_valid = 1'b0; dec_wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_raw();
    test_drain_order();
    test_hold();
    test_waw();
    test_reset_mid();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
